// File: rtl/wr_address_encoder_512.sv
// wr_address_encoder_512: packs 4-pixel words into 512-bit beats, double-buffers lines, writes them to DDR over AXI4.
// Latency: first AW of a line is presented 2 cycles after its end-of-line; W data follows each AW handshake by one cycle.
// Backpressure: none toward the pixel stream; when both line banks are still pending a whole line is dropped and out_ovf set.
module wr_address_encoder_512 #(
  parameter logic [7:0] BURST_LEN = 8'd16,
  parameter logic [2:0] FRAME_NUM = 3'd3
) (
  input  logic         axi_clk,
  input  logic         rstn,
  input  logic [11:0]  x_win,
  input  logic [11:0]  y_win,
  input  logic [11:0]  y_start,
  input  logic         in_vsync,
  input  logic         in_de,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic [2:0]   out_frame_cnt,
  output logic         out_ovf,
  output logic         aw_valid,
  input  logic         aw_ready,
  output logic [31:0]  aw_addr,
  output logic [7:0]   aw_len,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [511:0] w_data,
  output logic [63:0]  w_strb,
  output logic         w_last,
  input  logic         b_valid,
  output logic         b_ready
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} wst_t;

  // packer / line bookkeeping
  logic             vs_q, de_q, started;
  logic [2:0]       frame, pub_val;
  logic             pub_pend;
  logic [11:0]      y;
  logic             pk_bank, line_keep;
  logic [10:0]      wcnt;
  logic [511:0]     pack_dat;
  logic             pend_we;
  logic [6:0]       pend_idx;
  logic [1:0]       full;
  logic [1:0][6:0]  bank_beats;
  logic [1:0][11:0] bank_y;
  logic [1:0][2:0]  bank_frame;

  // line bank storage, indexed {bank, beat}
  logic [511:0]     ram [0:127];
  logic [511:0]     rd_dat;

  // write master
  wst_t             state, state_nxt;
  logic             rd_bank;
  logic [5:0]       beat;
  logic [6:0]       rem;
  logic [7:0]       bcnt, burst;

  logic vs_rise, de_rise, eol, line_ok, keep_now, accept, commit, flush, free_bank, ram_we;
  logic [6:0]  beats_eol, ram_wa;
  logic [12:0] px_lim;
  logic [2:0]  frame_nxt;

  assign vs_rise   = in_vsync & ~vs_q;
  assign de_rise   = in_de & ~de_q;
  assign eol       = de_q & ~in_de;
  assign line_ok   = (y < y_win) & ~full[pk_bank];
  assign keep_now  = de_rise ? line_ok : line_keep;
  // x_win of 0 stands for the full 4096-pixel line
  assign px_lim    = (x_win == 12'd0) ? 13'd4096 : {1'b0, x_win};
  assign accept    = in_de & in_valid & keep_now & ({wcnt, 2'b00} < px_lim);
  assign commit    = eol & line_keep & (wcnt != 11'd0);
  assign flush     = commit & (wcnt[3:0] != 4'd0);
  assign beats_eol = wcnt[10:4] + {6'd0, |wcnt[3:0]};
  assign ram_we    = pend_we | flush;
  assign ram_wa    = flush ? {pk_bank, wcnt[9:4]} : pend_idx;
  assign frame_nxt = (frame == FRAME_NUM - 3'd1) ? 3'd0 : frame + 3'd1;
  assign free_bank = (state == S_B) & b_valid & (rem == 7'd0);
  assign burst     = ({1'b0, rem} > BURST_LEN) ? BURST_LEN : {1'b0, rem};

  // Pixel-side packer, line bookkeeping, frame rotation and bank occupancy
  always_ff @(posedge axi_clk) begin
    if (!rstn) begin
      vs_q <= 1'b0;  de_q <= 1'b0;  started <= 1'b0;
      frame <= '0;  pub_pend <= 1'b0;  pub_val <= '0;
      out_frame_cnt <= '0;  out_ovf <= 1'b0;
      y <= '0;  pk_bank <= 1'b0;  line_keep <= 1'b0;  wcnt <= '0;
      pack_dat <= '0;  pend_we <= 1'b0;  pend_idx <= '0;
      full <= '0;  bank_beats <= '0;  bank_y <= '0;  bank_frame <= '0;
    end else begin
      vs_q    <= in_vsync;
      de_q    <= in_de;
      pend_we <= 1'b0;
      if (de_rise) begin
        line_keep <= line_ok;
        // a line that should be written but finds its bank still pending
        if ((y < y_win) && full[pk_bank]) out_ovf <= 1'b1;
      end
      if (accept) begin
        // starting a fresh beat clears the upper slots so a short last beat is zero-padded
        if (wcnt[3:0] == 4'd0) pack_dat <= {480'd0, in_data};
        else pack_dat[{wcnt[3:0], 5'd0} +: 32] <= in_data;
        wcnt <= wcnt + 11'd1;
        if (wcnt[3:0] == 4'hF) begin
          pend_we  <= 1'b1;
          pend_idx <= {pk_bank, wcnt[9:4]};
        end
      end
      if (eol) begin
        wcnt <= '0;
        y    <= y + 12'd1;
        if (commit) begin
          full[pk_bank]       <= 1'b1;
          bank_beats[pk_bank] <= beats_eol;
          bank_y[pk_bank]     <= y + y_start;
          bank_frame[pk_bank] <= frame;
          pk_bank             <= ~pk_bank;
        end
      end
      if (free_bank) full[rd_bank] <= 1'b0;
      if (pub_pend && (full == 2'b00) && (state == S_IDLE)) begin
        out_frame_cnt <= pub_val;
        pub_pend      <= 1'b0;
      end
      // the first vsync after reset opens frame 0 rather than rotating away from it
      if (vs_rise) begin
        y       <= '0;
        started <= 1'b1;
        if (started) begin
          frame    <= frame_nxt;
          pub_val  <= frame;
          pub_pend <= 1'b1;
        end
      end
    end
  end

  // Line bank RAM write port: completed beats and the end-of-line partial beat
  always_ff @(posedge axi_clk) begin
    if (ram_we) ram[ram_wa] <= pack_dat;
  end

  // Write FSM state register
  always_ff @(posedge axi_clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Write FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (full[rd_bank]) state_nxt = S_AW;
      S_AW:   if (aw_ready) state_nxt = S_W;
      S_W:    if (w_ready && (bcnt == 8'd1)) state_nxt = S_B;
      S_B:    if (b_valid) state_nxt = (rem != 7'd0) ? S_AW : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write FSM outputs; address/length derive from registers frozen while valid
  always_comb begin
    aw_valid = 1'b0;  aw_addr = '0;  aw_len = '0;
    w_valid  = 1'b0;  w_strb  = '0;  w_last = 1'b0;
    b_ready  = 1'b0;
    case (state)
      S_AW: begin
        aw_valid = 1'b1;
        aw_addr  = {5'd0, bank_frame[rd_bank], bank_y[rd_bank], beat, 6'd0};
        aw_len   = burst - 8'd1;
      end
      S_W: begin
        w_valid = 1'b1;
        w_strb  = '1;
        w_last  = (bcnt == 8'd1);
      end
      S_B:     b_ready = 1'b1;
      default: ;
    endcase
  end

  assign w_data = rd_dat;

  // Burst bookkeeping and RAM read-ahead: next beat is fetched on each handshake
  always_ff @(posedge axi_clk) begin
    if (!rstn) begin
      rd_bank <= 1'b0;  beat <= '0;  rem <= '0;  bcnt <= '0;  rd_dat <= '0;
    end else begin
      case (state)
        S_IDLE: if (full[rd_bank]) begin
          beat <= '0;
          rem  <= bank_beats[rd_bank];
        end
        S_AW: if (aw_ready) begin
          bcnt   <= burst;
          rd_dat <= ram[{rd_bank, beat}];
        end
        S_W: if (w_ready) begin
          beat   <= beat + 6'd1;
          rem    <= rem - 7'd1;
          bcnt   <= bcnt - 8'd1;
          rd_dat <= ram[{rd_bank, beat + 6'd1}];
        end
        S_B: if (free_bank) rd_bank <= ~rd_bank;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_address_encoder_512.sv
// tb_wr_address_encoder_512: directed line/frame scenarios against an AXI write slave model.
// Latency: n/a (bench).
// Backpressure: optional random aw/w stalls and a held-off b channel.
module tb_wr_address_encoder_512;

  logic         axi_clk = 1'b0;
  logic         rstn;
  logic [11:0]  x_win, y_win, y_start;
  logic         in_vsync, in_de, in_valid;
  logic [31:0]  in_data;
  logic [2:0]   out_frame_cnt;
  logic         out_ovf;
  logic         aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [31:0]  aw_addr;
  logic [7:0]   aw_len;
  logic [511:0] w_data;
  logic [63:0]  w_strb;

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;
  bit stall = 1'b0;
  bit b_hold = 1'b0;

  logic [31:0]  aw_addr_q [$];
  logic [7:0]   aw_len_q  [$];
  logic [511:0] w_dat_q   [$];
  logic         w_last_q  [$];

  logic         pav, pah, pwv, pwh, plast;
  logic [31:0]  pa;
  logic [7:0]   pl;
  logic [511:0] pd;

  always #5 axi_clk = ~axi_clk;

  wr_address_encoder_512 dut (
    .axi_clk(axi_clk), .rstn(rstn),
    .x_win(x_win), .y_win(y_win), .y_start(y_start),
    .in_vsync(in_vsync), .in_de(in_de), .in_valid(in_valid), .in_data(in_data),
    .out_frame_cnt(out_frame_cnt), .out_ovf(out_ovf),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready)
  );

  // slave ready/response drivers
  initial begin
    aw_ready = 1'b0;  w_ready = 1'b0;  b_valid = 1'b0;
    forever begin
      @(posedge axi_clk);
      #1;
      aw_ready = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
      w_ready  = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
      b_valid  = ~b_hold;
    end
  end

  // handshake recorder and valid-stability watcher
  initial begin
    pav = 1'b0;  pah = 1'b0;  pwv = 1'b0;  pwh = 1'b0;  plast = 1'b0;
    pa = '0;  pl = '0;  pd = '0;
    forever begin
      @(negedge axi_clk);
      if (!rstn) begin
        pav = 1'b0;  pwv = 1'b0;
      end else begin
        if (pav && !pah && (!aw_valid || aw_addr !== pa || aw_len !== pl)) viol++;
        if (pwv && !pwh && (!w_valid || w_data !== pd || w_last !== plast)) viol++;
        pah = aw_valid && aw_ready;
        pwh = w_valid && w_ready;
        if (pah) begin
          aw_addr_q.push_back(aw_addr);
          aw_len_q.push_back(aw_len);
        end
        if (pwh) begin
          w_dat_q.push_back(w_data);
          w_last_q.push_back(w_last);
          if (w_strb !== '1) viol++;
        end
        pav = aw_valid;  pa = aw_addr;  pl = aw_len;
        pwv = w_valid;   pd = w_data;   plast = w_last;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] word(input logic [7:0] tag, input int k);
    return {tag, 8'hA5, 16'(k)};
  endfunction

  // expected beat b of a line of nw words; slots past the line end are zero
  function automatic logic [511:0] model_beat(input logic [7:0] tag, input int nw, input int b);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      if (b * 16 + j < nw) r[j*32 +: 32] = word(tag, b * 16 + j);
    return r;
  endfunction

  task automatic chk_line(input int wbase, input logic [7:0] tag, input int nw);
    int nb;
    nb = (nw + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      if (wbase + b < w_dat_q.size()) begin
        chk($sformatf("w_data line%0h beat%0d", tag, b), w_dat_q[wbase + b], model_beat(tag, nw, b));
        chk($sformatf("w_last line%0h beat%0d", tag, b), 512'(w_last_q[wbase + b]),
            512'((b % 16 == 15) || (b == nb - 1)));
      end else begin
        chk($sformatf("w beat present line%0h beat%0d", tag, b), 512'(w_dat_q.size()), 512'(wbase + b + 1));
      end
    end
  endtask

  task automatic chk_aw(input int i, input logic [31:0] a, input logic [7:0] l);
    if (i < aw_addr_q.size()) begin
      chk($sformatf("aw_addr[%0d]", i), 512'(aw_addr_q[i]), 512'(a));
      chk($sformatf("aw_len[%0d]", i), 512'(aw_len_q[i]), 512'(l));
    end else begin
      chk($sformatf("aw present[%0d]", i), 512'(aw_addr_q.size()), 512'(i + 1));
    end
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 4000 && w_dat_q.size() < n; i++) tick(1);
    tick(20);
    chk("w beat count", 512'(w_dat_q.size()), 512'(n));
  endtask

  task automatic send_line(input logic [7:0] tag, input int nw);
    for (int k = 0; k < nw; k++) begin
      in_de = 1'b1;  in_valid = 1'b1;  in_data = word(tag, k);
      tick(1);
    end
    in_de = 1'b0;  in_valid = 1'b0;  in_data = '0;
    tick(1);
    // stray valid outside the active line must be ignored
    in_valid = 1'b1;  in_data = 32'hDEAD_BEEF;
    tick(1);
    in_valid = 1'b0;  in_data = '0;
    tick(3);
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    tick(2);
    in_vsync = 1'b0;
    tick(2);
  endtask

  task automatic do_reset(input logic [11:0] xw, input logic [11:0] yw, input logic [11:0] ys);
    rstn = 1'b0;  in_vsync = 1'b0;  in_de = 1'b0;  in_valid = 1'b0;  in_data = '0;
    x_win = xw;  y_win = yw;  y_start = ys;
    tick(3);
    rstn = 1'b1;
    tick(1);
    aw_addr_q.delete();  aw_len_q.delete();  w_dat_q.delete();  w_last_q.delete();
  endtask

  initial begin
    rstn = 1'b0;  in_vsync = 1'b0;  in_de = 1'b0;  in_valid = 1'b0;  in_data = '0;
    x_win = 12'd64;  y_win = 12'd2;  y_start = 12'd0;
    tick(3);
    chk("rst aw_valid", 512'(aw_valid), 512'(0));
    chk("rst w_valid", 512'(w_valid), 512'(0));
    chk("rst b_ready", 512'(b_ready), 512'(0));
    chk("rst w_last", 512'(w_last), 512'(0));
    chk("rst aw_addr", 512'(aw_addr), 512'(0));
    chk("rst aw_len", 512'(aw_len), 512'(0));
    chk("rst w_strb", 512'(w_strb), 512'(0));
    chk("rst w_data", w_data, 512'(0));
    chk("rst out_frame_cnt", 512'(out_frame_cnt), 512'(0));
    chk("rst out_ovf", 512'(out_ovf), 512'(0));
    rstn = 1'b1;
    tick(1);

    // 64 px lines, y_win=2: one single-beat burst per line, third line outside window
    vsync_pulse();
    send_line(8'h01, 16);
    send_line(8'h02, 16);
    send_line(8'h03, 16);
    wait_beats(2);
    chk("aw count 64px", 512'(aw_addr_q.size()), 512'(2));
    chk_aw(0, 32'h0000_0000, 8'd0);
    chk_aw(1, 32'h0000_1000, 8'd0);
    chk_line(0, 8'h01, 16);
    chk_line(1, 8'h02, 16);

    // 100 px = 25 words -> 2 beats, second beat slots 9..15 zero
    do_reset(12'd100, 12'd4, 12'd0);
    vsync_pulse();
    send_line(8'h11, 25);
    wait_beats(2);
    chk("aw count 100px", 512'(aw_addr_q.size()), 512'(1));
    chk_aw(0, 32'h0000_0000, 8'd1);
    chk_line(0, 8'h11, 25);

    // 1920 px = 480 words = 30 beats -> bursts of 16 and 14 beats, random aw/w stalls
    do_reset(12'd1920, 12'd4, 12'd0);
    stall = 1'b1;
    vsync_pulse();
    send_line(8'h21, 480);
    send_line(8'h22, 480);
    wait_beats(60);
    stall = 1'b0;
    chk("aw count 1920px", 512'(aw_addr_q.size()), 512'(4));
    chk_aw(0, 32'h0000_0000, 8'd15);
    chk_aw(1, 32'h0000_0400, 8'd13);
    chk_aw(2, 32'h0000_1000, 8'd15);
    chk_aw(3, 32'h0000_1400, 8'd13);
    chk_line(0, 8'h21, 480);
    chk_line(30, 8'h22, 480);
    chk("stable while valid", 512'(viol), 512'(0));

    // b held off: line 3 finds both banks pending and is dropped
    do_reset(12'd64, 12'd8, 12'd0);
    b_hold = 1'b1;
    vsync_pulse();
    send_line(8'h31, 16);
    send_line(8'h32, 16);
    tick(10);
    chk("ovf before drop", 512'(out_ovf), 512'(0));
    send_line(8'h33, 16);
    chk("ovf after drop", 512'(out_ovf), 512'(1));
    b_hold = 1'b0;
    wait_beats(2);
    send_line(8'h34, 16);
    wait_beats(3);
    chk("aw count ovf", 512'(aw_addr_q.size()), 512'(3));
    chk_aw(0, 32'h0000_0000, 8'd0);
    chk_aw(1, 32'h0000_1000, 8'd0);
    chk_aw(2, 32'h0000_3000, 8'd0);
    chk_line(0, 8'h31, 16);
    chk_line(1, 8'h32, 16);
    chk_line(2, 8'h34, 16);
    chk("ovf sticky", 512'(out_ovf), 512'(1));

    // four frames with y_start=8: frame field 0,1,2,0; published index lags by one frame
    do_reset(12'd64, 12'd1, 12'd8);
    for (int f = 0; f < 4; f++) begin
      vsync_pulse();
      tick(4);
      chk($sformatf("out_frame_cnt f%0d", f), 512'(out_frame_cnt), 512'((f == 0) ? 0 : f - 1));
      send_line(8'(8'h40 + f), 16);
      tick(30);
    end
    chk("aw count frames", 512'(aw_addr_q.size()), 512'(4));
    for (int f = 0; f < 4; f++) begin
      chk_aw(f, {5'd0, 3'(f % 3), 12'd8, 12'd0}, 8'd0);
      chk_line(f, 8'(8'h40 + f), 16);
    end
    chk("stable at end", 512'(viol), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
